// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep tester: reference-gate mode codes and FSM state encoding.
package gate_sweep_pkg;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/gate_sweep_tester_gate_ref_n.sv
// Combinational N-input reference gate; valid is low for the reserved mode codes.
module gate_ref_n
  import gate_sweep_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] in_vec,
  input  logic [2:0]   mode,
  output logic         y,
  output logic         valid
);

  always_comb begin
    y     = 1'b0;
    valid = 1'b1;
    case (mode)
      MODE_AND:  y = &in_vec;
      MODE_OR:   y = |in_vec;
      MODE_NAND: y = ~&in_vec;
      MODE_NOR:  y = ~|in_vec;
      MODE_XOR:  y = ^in_vec;
      MODE_XNOR: y = ~^in_vec;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_tester.sv
// Sweeps an external N-input gate through all 2^N patterns with a fixed dwell and records its truth table.
// Optional reference comparison enabled by defining SWEEP_SELFCHECK_EN.
module gate_sweep_tester
  import gate_sweep_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      mode,
  input  logic            dut_y,
  output logic [N-1:0]    in_vec,
  output logic            busy,
  output logic            done,
  output logic [2**N-1:0] truth_table,
  output logic [N:0]      mismatch_cnt,
  output logic            err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int MC_W  = N + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [N-1:0]     LAST_PAT   = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dwell_q;
  logic             load, sample_en, last_pat;

  assign last_pat = (in_vec == LAST_PAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    sample_en = 1'b0;
    busy      = (state_q == ST_DRIVE);
    done      = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          load    = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (dwell_q == '0) begin
          sample_en = 1'b1;
          if (last_pat) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // abort overrides any start or sample decided above
    if (abort) begin
      state_d   = ST_IDLE;
      load      = 1'b0;
      sample_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vec      <= '0;
      truth_table <= '0;
      dwell_q     <= '0;
    end else if (abort) begin
      in_vec <= '0;
    end else if (load) begin
      in_vec      <= '0;
      truth_table <= '0;
      dwell_q     <= CNT_RELOAD;
    end else if (sample_en) begin
      truth_table[in_vec] <= dut_y;
      dwell_q             <= CNT_RELOAD;
      in_vec              <= last_pat ? '0 : in_vec + N'(1);
    end else if (state_q == ST_DRIVE) begin
      dwell_q <= dwell_q - CNT_W'(1);
    end
  end

`ifdef SWEEP_SELFCHECK_EN
  logic [2:0] mode_q;
  logic       ref_y, ref_valid;

  gate_ref_n #(.N(N)) u_ref (
    .in_vec (in_vec),
    .mode   (mode_q),
    .y      (ref_y),
    .valid  (ref_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= '0;
      mismatch_cnt <= '0;
    end else if (load) begin
      mode_q       <= mode;
      mismatch_cnt <= '0;
    end else if (sample_en && ref_valid && (ref_y != dut_y)) begin
      mismatch_cnt <= mismatch_cnt + MC_W'(1);
    end
  end

  assign err = |mismatch_cnt;
`else
  logic mode_unused;
  assign mode_unused  = ^mode;
  assign mismatch_cnt = '0;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_gate_sweep_tester.sv
// Directed bench for gate_sweep_tester: N=3/DWELL=4 instance plus an N=1/DWELL=1 instance.
module tb_gate_sweep_tester;
  import gate_sweep_pkg::*;

`ifdef SWEEP_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: N=3, DWELL=4
  logic       start_a = 1'b0, abort_a = 1'b0, stuck_a = 1'b0;
  logic [2:0] mode_a = MODE_NAND;
  logic       dut_y_a;
  logic [2:0] in_vec_a;
  logic       busy_a, done_a, err_a;
  logic [7:0] tt_a;
  logic [3:0] mm_a;

  assign dut_y_a = stuck_a ? 1'b1 : ~&in_vec_a;

  gate_sweep_tester #(.N(3), .DWELL(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .mode(mode_a),
    .dut_y(dut_y_a), .in_vec(in_vec_a), .busy(busy_a), .done(done_a),
    .truth_table(tt_a), .mismatch_cnt(mm_a), .err(err_a)
  );

  // instance B: N=1, DWELL=1, XOR reference, gate is a wire
  logic       start_b = 1'b0, abort_b = 1'b0;
  logic [2:0] mode_b = MODE_XOR;
  logic       dut_y_b;
  logic [0:0] in_vec_b;
  logic       busy_b, done_b, err_b;
  logic [1:0] tt_b;
  logic [1:0] mm_b;

  assign dut_y_b = in_vec_b[0];

  gate_sweep_tester #(.N(1), .DWELL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .mode(mode_b),
    .dut_y(dut_y_b), .in_vec(in_vec_b), .busy(busy_b), .done(done_b),
    .truth_table(tt_b), .mismatch_cnt(mm_b), .err(err_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit q_tt[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_gate(input logic [7:0] v, input int n, input logic [2:0] m);
    bit a = 1'b1, o = 1'b0, x = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = a & v[i];
      o = o | v[i];
      x = x ^ v[i];
    end
    case (m)
      3'd0: return a;
      3'd1: return o;
      3'd2: return !a;
      3'd3: return !o;
      3'd4: return x;
      default: return !x;
    endcase
  endfunction

  // Full sweep on instance A with the scoreboard tracking every sampled pattern.
  task automatic sweep_a(input bit stuck, input logic [2:0] m);
    logic [7:0] exp_tt = '0;
    int exp_mm = 0;
    bit y, e;
    stuck_a = stuck;
    mode_a  = m;
    for (int p = 0; p < 8; p++) begin
      y = stuck ? 1'b1 : !(p[0] & p[1] & p[2]);
      q_tt.push_back(y);
      exp_tt[p] = y;
      if (SC && m <= 3'd5 && ref_gate(8'(p), 3, m) != y) exp_mm++;
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_start_clears_tt", {24'd0, tt_a}, 32'd0);
    for (int p = 0; p < 8; p++) begin
      for (int d = 0; d < 4; d++) begin
        if (d == 0) check($sformatf("a_busy_p%0d", p), {31'd0, busy_a}, 32'd1);
        check($sformatf("a_in_vec_p%0d_d%0d", p, d), {29'd0, in_vec_a}, p);
        tick();
      end
      e = q_tt.pop_front();
      check($sformatf("a_tt_bit%0d", p), {31'd0, tt_a[p]}, {31'd0, e});
    end
    check("a_done", {31'd0, done_a}, 32'd1);
    check("a_busy_end", {31'd0, busy_a}, 32'd0);
    check("a_in_vec_end", {29'd0, in_vec_a}, 32'd0);
    check("a_tt_full", {24'd0, tt_a}, {24'd0, exp_tt});
    check("a_mismatch", {28'd0, mm_a}, exp_mm);
    check("a_err", {31'd0, err_a}, (exp_mm != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #2;
    check("rst_a_in_vec", {29'd0, in_vec_a}, 32'd0);
    check("rst_a_busy", {31'd0, busy_a}, 32'd0);
    check("rst_a_done", {31'd0, done_a}, 32'd0);
    check("rst_a_tt", {24'd0, tt_a}, 32'd0);
    check("rst_a_mm", {28'd0, mm_a}, 32'd0);
    check("rst_b_done", {31'd0, done_b}, 32'd0);
    #5 rst_n = 1'b1;
    tick();

    // correct NAND gate, then stuck-at-1 gate
    sweep_a(1'b0, MODE_NAND);
    sweep_a(1'b1, MODE_NAND);

    // restart ignored mid-sweep, then abort keeps partial results
    stuck_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart_ignored_in_vec", {29'd0, in_vec_a}, 32'd1);
    check("restart_ignored_busy", {31'd0, busy_a}, 32'd1);
    repeat (4) tick();
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_done", {31'd0, done_a}, 32'd0);
    check("abort_in_vec", {29'd0, in_vec_a}, 32'd0);
    check("abort_tt_partial", {24'd0, tt_a}, 32'h03);
    tick();
    check("abort_stays_idle", {31'd0, busy_a}, 32'd0);

    // asynchronous reset mid-sweep
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (13) tick();
    check("pre_reset_tt", {24'd0, tt_a}, 32'h07);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_vec", {29'd0, in_vec_a}, 32'd0);
    check("async_rst_busy", {31'd0, busy_a}, 32'd0);
    check("async_rst_done", {31'd0, done_a}, 32'd0);
    check("async_rst_tt", {24'd0, tt_a}, 32'd0);
    check("async_rst_mm", {28'd0, mm_a}, 32'd0);
    check("async_rst_err", {31'd0, err_a}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    sweep_a(1'b0, MODE_NAND);

    // reserved mode disables comparison
    sweep_a(1'b1, 3'd6);

    // instance B: two-pattern sweep, then restart from DONE
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_busy", {31'd0, busy_b}, 32'd1);
    check("b_in_vec0", {31'd0, in_vec_b}, 32'd0);
    tick();
    check("b_in_vec1", {31'd0, in_vec_b}, 32'd1);
    tick();
    check("b_done", {31'd0, done_b}, 32'd1);
    check("b_tt", {30'd0, tt_b}, 32'd2);
    check("b_mm", {30'd0, mm_b}, 32'd0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_restart_tt_clear", {30'd0, tt_b}, 32'd0);
    check("b_restart_busy", {31'd0, busy_b}, 32'd1);
    check("b_restart_done", {31'd0, done_b}, 32'd0);
    repeat (2) tick();
    check("b_done2", {31'd0, done_b}, 32'd1);
    check("b_tt2", {30'd0, tt_b}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
